ponto_fixo_mult_arbiter: RTL and testbench



---
 rtl/ponto_fixo_mult_arbiter.sv | 151 +++++++++++++++
 tb/tb_ponto_fixo_mult_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ponto_fixo_mult_arbiter.sv
// Round-robin arbiter that time-shares one unsigned Qm.n fixed-point multiplier
// between two requesters and returns each tagged result on a valid/ready channel.
module ponto_fixo_mult_arbiter #(
   parameter int N        = 8,
   parameter int NFRAC    = 3,
   parameter int SATURATE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [N-1:0]   req_a0,
   input  logic [N-1:0]   req_b0,
   input  logic [N-1:0]   req_a1,
   input  logic [N-1:0]   req_b1,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [N-1:0]   rsp_p,
   output logic [2*N-1:0] rsp_raw,
   output logic           rsp_ovf,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   localparam logic [2*N:0] HALF_LSB = (2*N+1)'(1) << (NFRAC - 1);

   state_t         state_q, state_d;
   logic           last_q, last_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           busy_q, busy_d;
   logic           rsp_id_q, rsp_id_d;
   logic [N-1:0]   rsp_p_q, rsp_p_d;
   logic [2*N-1:0] rsp_raw_q, rsp_raw_d;
   logic           rsp_ovf_q, rsp_ovf_d;

   logic [1:0]     grant;
   logic [1:0]     accept;
   logic [2*N-1:0] mul_raw;
   logic [2*N:0]   mul_sum;
   logic [2*N:0]   mul_rnd;
   logic           mul_ovf;
   logic [N-1:0]   mul_p;

   // On a tie the channel that was not served last wins.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready = (state_q == IDLE) ? grant : 2'b00;
   assign accept    = req_valid & req_ready;

   // Shared multiplier: round half-up at the binary point, then clamp or wrap.
   assign mul_raw = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
   assign mul_sum = {1'b0, mul_raw} + HALF_LSB;
   assign mul_rnd = mul_sum >> NFRAC;
   assign mul_ovf = |mul_rnd[2*N:N];
   assign mul_p   = (mul_ovf && (SATURATE != 0)) ? {N{1'b1}} : mul_rnd[N-1:0];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      rsp_id_d    = rsp_id_q;
      rsp_p_d     = rsp_p_q;
      rsp_raw_d   = rsp_raw_q;
      rsp_ovf_d   = rsp_ovf_q;
      case (state_q)
         IDLE: begin
            if (|accept) begin
               state_d = CALC;
               busy_d  = 1'b1;
               id_d    = accept[1];
               last_d  = accept[1];
               a_d     = accept[1] ? req_a1 : req_a0;
               b_d     = accept[1] ? req_b1 : req_b0;
            end
         end
         CALC: begin
            state_d     = HOLD;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_p_d     = mul_p;
            rsp_raw_d   = mul_raw;
            rsp_ovf_d   = mul_ovf;
         end
         HOLD: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_p_q     <= '0;
         rsp_raw_q   <= '0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         rsp_id_q    <= rsp_id_d;
         rsp_p_q     <= rsp_p_d;
         rsp_raw_q   <= rsp_raw_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign busy      = busy_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_raw   = rsp_raw_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_ponto_fixo_mult_arbiter.sv
// Bench for ponto_fixo_mult_arbiter: vector table plus scoreboard, with a
// second wrapping (SATURATE=0) instance driven by the same stimulus.
module tb_ponto_fixo_mult_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [7:0]  req_a0 = 8'h00, req_b0 = 8'h00, req_a1 = 8'h00, req_b1 = 8'h00;
   logic        rsp_ready = 1'b0;

   logic [1:0]  req_ready, w_req_ready;
   logic        rsp_valid, w_rsp_valid;
   logic        rsp_id, w_rsp_id;
   logic [7:0]  rsp_p, w_rsp_p;
   logic [15:0] rsp_raw, w_rsp_raw;
   logic        rsp_ovf, w_rsp_ovf;
   logic        busy, w_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ponto_fixo_mult_arbiter #(.N(8), .NFRAC(3), .SATURATE(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_p(rsp_p), .rsp_raw(rsp_raw), .rsp_ovf(rsp_ovf), .busy(busy)
   );

   ponto_fixo_mult_arbiter #(.N(8), .NFRAC(3), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
      .rsp_p(w_rsp_p), .rsp_raw(w_rsp_raw), .rsp_ovf(w_rsp_ovf), .busy(w_busy)
   );

   typedef struct {
      logic        id;
      logic [15:0] raw;
      logic [7:0]  p;
      logic [7:0]  pw;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [1:0] v;
      logic [7:0] a0, b0, a1, b1;
      int         stall;
      logic       exp_id;
      logic [7:0] exp_p;
      logic       exp_ovf;
   } vec_t;

   exp_t sb[$];
   logic last_m = 1'b1;
   logic chk_onehot = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      logic [16:0] s;
      logic [16:0] r;
      e.id  = id;
      e.raw = 16'(a) * 16'(b);
      s     = {1'b0, e.raw} + 17'd4;
      r     = s >> 3;
      e.ovf = (r > 17'd255);
      e.p   = e.ovf ? 8'hFF : r[7:0];
      e.pw  = r[7:0];
      return e;
   endfunction

   function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_onehot) check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
   end

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_raw", 32'(rsp_raw), 32'd0);
      check("rst_rsp_p", 32'(rsp_p), 32'd0);
      rst = 1'b0;
      last_m = 1'b1;
      sb.delete();
   endtask

   // Starts at a negedge with the DUT idle; returns at a negedge with it idle again.
   task automatic run_txn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1, input int stall,
                          input logic idle_rdy, input logic chk_id, input logic exp_id,
                          input logic chk_p, input logic [7:0] exp_p);
      logic [1:0] g;
      exp_t       e;
      req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
      rsp_ready = idle_rdy;
      #1;
      g = model_grant(v, last_m);
      check("idle_req_ready", 32'(req_ready), 32'(g));
      check("idle_req_ready_wrap", 32'(w_req_ready), 32'(g));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      sb.push_back(g[1] ? model(1'b1, a1, b1) : model(1'b0, a0, b0));
      last_m = g[1];
      @(negedge clk);
      check("calc_req_ready", 32'(req_ready), 32'd0);
      check("calc_busy", 32'(busy), 32'd1);
      check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_valid_wrap", 32'(w_rsp_valid), 32'd1);
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         e = model(1'b0, 8'h00, 8'h00);
      end else begin
         e = sb.pop_front();
      end
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_id_wrap", 32'(w_rsp_id), 32'(e.id));
      check("rsp_raw", 32'(rsp_raw), 32'(e.raw));
      check("rsp_raw_wrap", 32'(w_rsp_raw), 32'(e.raw));
      check("rsp_p", 32'(rsp_p), 32'(e.p));
      check("rsp_p_wrap", 32'(w_rsp_p), 32'(e.pw));
      check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      check("rsp_ovf_wrap", 32'(w_rsp_ovf), 32'(e.ovf));
      if (chk_id) check("tbl_rsp_id", 32'(rsp_id), 32'(exp_id));
      if (chk_p) check("tbl_rsp_p", 32'(rsp_p), 32'(exp_p));
      if (stall > 0) begin
         rsp_ready = 1'b0;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_p", 32'(rsp_p), 32'(e.p));
            check("stall_rsp_raw", 32'(rsp_raw), 32'(e.raw));
            check("stall_rsp_id", 32'(rsp_id), 32'(e.id));
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("done_rsp_valid", 32'(rsp_valid), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("done_busy_wrap", 32'(w_busy), 32'd0);
      rsp_ready = idle_rdy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{2'b01, 8'h3C, 8'h12, 8'h00, 8'h00, 0, 1'b0, 8'h87, 1'b0};
      tbl[1] = '{2'b10, 8'h00, 8'h00, 8'h39, 8'h3C, 0, 1'b1, 8'hFF, 1'b1};
      tbl[2] = '{2'b11, 8'h01, 8'h04, 8'h01, 8'h03, 0, 1'b0, 8'h01, 1'b0};
      tbl[3] = '{2'b11, 8'h01, 8'h04, 8'h01, 8'h03, 0, 1'b1, 8'h00, 1'b0};
      tbl[4] = '{2'b01, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0};
      tbl[5] = '{2'b11, 8'hFF, 8'hFF, 8'h10, 8'h10, 0, 1'b1, 8'h20, 1'b0};
      tbl[6] = '{2'b11, 8'hFF, 8'hFF, 8'h10, 8'h10, 0, 1'b0, 8'hFF, 1'b1};
      tbl[7] = '{2'b10, 8'h00, 8'h00, 8'h10, 8'h10, 5, 1'b1, 8'h20, 1'b0};

      do_reset();
      chk_onehot = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].stall,
                 1'b0, 1'b1, tbl[i].exp_id, 1'b1, tbl[i].exp_p);
         check("tbl_rsp_ovf", 32'(rsp_ovf), 32'(tbl[i].exp_ovf));
      end
      req_valid = 2'b00;

      // Both channels requesting continuously, consumer always ready.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_txn(2'b11, 8'(i + 1), 8'h20, 8'(8'h40 + i), 8'h08, 0,
                 1'b1, 1'b1, 1'(i % 2), 1'b0, 8'h00);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      @(negedge clk);

      // Reset during CALC.
      req_valid = 2'b10; req_a1 = 8'h39; req_b1 = 8'h3C;
      #1;
      check("r5_grant_ch1", 32'(req_ready), 32'(model_grant(2'b10, last_m)));
      last_m = 1'b1;
      @(negedge clk);
      check("r5_calc_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("r5_calc_rst_valid", 32'(rsp_valid), 32'd0);
      check("r5_calc_rst_busy", 32'(busy), 32'd0);
      check("r5_calc_rst_raw", 32'(rsp_raw), 32'd0);
      rst = 1'b0;
      req_valid = 2'b00;
      last_m = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("r5_no_stale_calc", 32'(rsp_valid), 32'd0);
      end

      // Reset during HOLD.
      req_valid = 2'b11; req_a0 = 8'h3C; req_b0 = 8'h12; req_a1 = 8'hFF; req_b1 = 8'hFF;
      #1;
      check("r5_tie_grant", 32'(req_ready), 32'(model_grant(2'b11, last_m)));
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("r5_hold_valid", 32'(rsp_valid), 32'd1);
      check("r5_hold_id", 32'(rsp_id), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("r5_hold_rst_valid", 32'(rsp_valid), 32'd0);
      check("r5_hold_rst_busy", 32'(busy), 32'd0);
      check("r5_hold_rst_p", 32'(rsp_p), 32'd0);
      rst = 1'b0;
      last_m = 1'b1;
      sb.delete();
      rsp_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("r5_no_stale_hold", 32'(rsp_valid), 32'd0);
      end
      rsp_ready = 1'b0;

      // First tie after reset must go to channel 0 again.
      run_txn(2'b11, 8'h01, 8'h04, 8'h39, 8'h3C, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
      req_valid = 2'b00;
      @(negedge clk);
      check("end_sb_empty", 32'(sb.size()), 32'd0);

      chk_onehot = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
